// File: rtl/spi_pkg.sv
// Shared SPI master types: controller state encoding and the SPI mode constants.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_XFER  = 2'd2,
    ST_TRAIL = 2'd3
  } spi_state_e;

  // Mode 0: SCLK idles low, data sampled on the leading (rising) edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: toggles SCLK every CLK_DIV enabled cycles and flags the
// cycle before each rising/falling toggle so the controller acts on the same edge.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_enable,
  output logic o_sclk,
  output logic o_rise_stb,
  output logic o_fall_stb
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_sclk;
  logic             w_term;

  assign w_term = i_enable && (r_div == DIV_LAST);

  // Half-period counter; SCLK parks at its idle level whenever disabled.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_div  <= '0;
      r_sclk <= SPI_CPOL;
    end else if (!i_enable) begin
      r_div  <= '0;
      r_sclk <= SPI_CPOL;
    end else if (w_term) begin
      r_div  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_div  <= r_div + DIV_W'(1);
    end
  end

  assign o_sclk     = r_sclk;
  assign o_rise_stb = w_term && !r_sclk;
  assign o_fall_stb = w_term && r_sclk;

endmodule

// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master: one DATA_WIDTH frame per request, MSB first, with
// CLK_DIV-cycle chip-select lead and trail guard phases. All outputs registered.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_tx_valid,
  output logic                  o_tx_ready,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  output logic                  o_busy,
  output logic                  o_sclk,
  output logic                  o_cs_n,
  output logic                  o_mosi,
  input  logic                  i_miso
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH);

  spi_state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_tx, r_rx;
  logic [DATA_WIDTH-1:0] r_rx_data, w_rx_data_nxt;
  logic                  r_cs_n, w_cs_n_nxt;
  logic                  r_mosi, w_mosi_nxt;
  logic                  r_tx_ready, w_tx_ready_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_rx_valid, w_rx_valid_nxt;
  logic                  w_sclk, w_rise_stb, w_fall_stb;
  logic                  w_sample_stb, w_shift_stb;
  logic                  w_accept, w_last_bit, w_xfer_en;

  assign w_xfer_en  = (r_state == ST_XFER);
  assign w_accept   = (r_state == ST_IDLE) && r_tx_ready && i_tx_valid;
  assign w_last_bit = (r_bit_cnt == BIT_LAST);

  // With CPHA=0 the leading edge samples and the trailing edge shifts.
  assign w_sample_stb = (SPI_CPHA == 1'b0) ? w_rise_stb : w_fall_stb;
  assign w_shift_stb  = (SPI_CPHA == 1'b0) ? w_fall_stb : w_rise_stb;

  spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_enable  (w_xfer_en),
    .o_sclk    (w_sclk),
    .o_rise_stb(w_rise_stb),
    .o_fall_stb(w_fall_stb)
  );

  // State register and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_cs_n     <= 1'b1;
      r_mosi     <= 1'b1;
      r_tx_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '1;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cs_n     <= w_cs_n_nxt;
      r_mosi     <= w_mosi_nxt;
      r_tx_ready <= w_tx_ready_nxt;
      r_busy     <= w_busy_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_rx_data  <= w_rx_data_nxt;
    end
  end

  // Next-state and next-output decode; outputs are computed one cycle ahead.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_cs_n_nxt     = r_cs_n;
    w_mosi_nxt     = r_mosi;
    w_tx_ready_nxt = r_tx_ready;
    w_busy_nxt     = r_busy;
    w_rx_valid_nxt = 1'b0;
    w_rx_data_nxt  = r_rx_data;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt    = ST_LEAD;
          w_cnt_nxt      = '0;
          w_cs_n_nxt     = 1'b0;
          w_mosi_nxt     = i_tx_data[DATA_WIDTH-1];
          w_tx_ready_nxt = 1'b0;
          w_busy_nxt     = 1'b1;
        end else begin
          w_cs_n_nxt     = 1'b1;
          w_mosi_nxt     = 1'b1;
          w_tx_ready_nxt = 1'b1;
          w_busy_nxt     = 1'b0;
        end
      end
      ST_LEAD: begin
        w_mosi_nxt = r_tx[DATA_WIDTH-1];
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_XFER;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      ST_XFER: begin
        if (w_shift_stb) begin
          if (w_last_bit) begin
            w_state_nxt = ST_TRAIL;
            w_cnt_nxt   = '0;
          end else begin
            w_mosi_nxt  = r_tx[DATA_WIDTH-2];
          end
        end
      end
      ST_TRAIL: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt    = ST_IDLE;
          w_cs_n_nxt     = 1'b1;
          w_mosi_nxt     = 1'b1;
          w_tx_ready_nxt = 1'b1;
          w_busy_nxt     = 1'b0;
          w_rx_valid_nxt = 1'b1;
          w_rx_data_nxt  = r_rx;
        end else begin
          w_cnt_nxt      = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Shift registers and bit counter; the counter stops at DATA_WIDTH.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_tx      <= '1;
      r_rx      <= '1;
      r_bit_cnt <= '0;
    end else if (w_accept) begin
      r_tx      <= i_tx_data;
      r_bit_cnt <= '0;
    end else if (w_xfer_en) begin
      if (w_sample_stb) begin
        r_rx      <= {r_rx[DATA_WIDTH-2:0], i_miso};
        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
      end
      if (w_shift_stb && !w_last_bit) begin
        r_tx      <= {r_tx[DATA_WIDTH-2:0], 1'b1};
      end
    end
  end

  assign o_tx_ready = r_tx_ready;
  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_busy     = r_busy;
  assign o_sclk     = w_sclk;
  assign o_cs_n     = r_cs_n;
  assign o_mosi     = r_mosi;

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bits per SPI frame; legal range 2 or more.
REQ-002 SHALL have parameter CLK_DIV, default 4: i_clk cycles per SCLK half-period; legal range 1 or more.
REQ-003 i_clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 i_rst  in  1  reset, asynchronous assert, active-low.
REQ-005 i_tx_data  in  DATA_WIDTH  frame to transmit, MSB first.
REQ-006 i_tx_valid  in  1  transmit request; accepted when i_tx_valid and o_tx_ready are both 1 on an i_clk edge.
REQ-007 o_tx_ready  out  1  high only in IDLE.
REQ-008 o_rx_data  out  DATA_WIDTH  last received frame; holds until the next frame completes.
REQ-009 o_rx_valid  out  1  one-cycle pulse when o_rx_data updates.
REQ-010 o_busy  out  1  high in every state except IDLE.
REQ-011 o_sclk  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-012 o_cs_n  out  1  chip select, active-low.
REQ-013 o_mosi  out  1  serial data out.
REQ-014 i_miso  in  1  serial data in; already synchronous to i_clk.

Function
REQ-015 SHALL implement FSM states IDLE, LEAD, XFER, TRAIL.
REQ-016 IDLE: o_cs_n=1, o_sclk=0, o_mosi=1, o_tx_ready=1; on accept, latch i_tx_data into the tx shift register and go to LEAD on the next cycle.
REQ-017 LEAD: o_cs_n=0, o_sclk=0, o_mosi=tx[DATA_WIDTH-1]; lasts exactly CLK_DIV cycles, then go to XFER.
REQ-018 XFER: a divider counter counts 0..CLK_DIV-1 and toggles o_sclk at the terminal count, starting from o_sclk=0.
REQ-019 On each SCLK rising toggle: sample i_miso into rx shift register LSB (shift left) and increment the bit counter.
REQ-020 On each SCLK falling toggle, except the last: shift tx left, filling the LSB with 1, so o_mosi presents the next bit.
REQ-021 XFER lasts exactly 2*CLK_DIV*DATA_WIDTH cycles and ends with o_sclk=0 after the DATA_WIDTH-th falling toggle; then go to TRAIL.
REQ-022 TRAIL: o_cs_n=0, o_sclk=0 for CLK_DIV cycles, then go to IDLE; on the same edge, drive o_rx_data with the rx register and pulse o_rx_valid for 1 cycle.
REQ-023 Total o_cs_n low time SHALL be CLK_DIV*(2*DATA_WIDTH+2) cycles.
REQ-024 The bit counter SHALL be ceil(log2(DATA_WIDTH+1)) bits wide and SHALL never wrap within a frame.
REQ-025 i_tx_valid while busy SHALL be ignored; the request is neither queued nor lost, it simply waits for o_tx_ready.
REQ-026 Back-to-back frames: o_tx_ready SHALL be 1 in the same cycle as o_rx_valid; an accept then starts LEAD on the next cycle.
REQ-027 All outputs SHALL be registered; o_sclk SHALL carry no combinational glitch.

Reset
REQ-028 While i_rst=0, outputs SHALL be: o_cs_n=1, o_sclk=0, o_mosi=1, o_tx_ready=0, o_busy=0, o_rx_valid=0, o_rx_data=all ones; FSM in IDLE; tx/rx registers all ones; counters 0.
REQ-029 o_tx_ready SHALL rise on the first i_clk edge after i_rst deasserts.
REQ-030 Reset asserted mid-frame SHALL force o_cs_n=1 and o_sclk=0 immediately, with no o_rx_valid pulse.

Structure
REQ-031 Package spi_pkg SHALL hold the FSM state enum and the SPI mode constants (CPOL/CPHA = 0).
REQ-032 SCLK divider and edge-strobe generation SHALL be sub-module spi_sclk_gen: inputs enable; outputs sclk, rise_stb, fall_stb.

Verification
REQ-033 Use DATA_WIDTH=8, CLK_DIV=2, MISO looped to MOSI; send 0xA5 -> o_rx_data=0xA5, one o_rx_valid pulse, o_cs_n low 36 cycles, 8 SCLK pulses.
REQ-034 Use i_miso driven from pattern 0x3C, tx 0xFF -> o_mosi stays 1 throughout, o_rx_data=0x3C.
REQ-035 Hold i_tx_valid high with 0x01 then 0x80 -> two frames, o_cs_n high for exactly 1 cycle between them, rx order preserved.
REQ-036 Assert i_rst at the 4th SCLK rise -> o_cs_n=1 and o_sclk=0 same cycle, no o_rx_valid; next frame 0x5A after release completes correctly.
REQ-037 Use CLK_DIV=1, send 0x81 -> SCLK period 2 cycles, o_cs_n low 18 cycles, o_rx_data=0x81 with loopback.
REQ-038 Pulse i_tx_valid during XFER -> ignored; o_tx_ready stays 0 and the frame is unaffected.
